// File: rtl/cmp_pkg.sv
// Shared types and defaults for the max-scan sequencer and its comparator.
package cmp_pkg;
    localparam int N_DEF  = 8;
    localparam int W_DEF  = 4;
    localparam int IW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot so a single bit test selects the update path.
    typedef enum logic [2:0] {
        LT = 3'b001,
        EQ = 3'b010,
        GT = 3'b100
    } cmp_res_t;
endpackage

// File: rtl/cmp_max_scan_if.sv
// Host-side bundle for cmp_max_scan: entry-file writes, scan start, and scan results.
interface cmp_max_scan_if
    import cmp_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
);
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  max_val;
    logic [IW-1:0] max_idx;
    logic [IW:0]   tie_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, max_val, max_idx, tie_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, max_val, max_idx, tie_cnt
    );
endinterface

// File: rtl/cmp_unit.sv
// Combinational W-bit unsigned magnitude compare of i_a against i_b, one-hot LT/EQ/GT result.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output cmp_res_t     o_res
);
    always_comb begin
        o_res = EQ;
        if (i_a > i_b)      o_res = GT;
        else if (i_a < i_b) o_res = LT;
    end
endmodule

// File: rtl/cmp_max_scan.sv
// Scans an N-entry register file for max value, first index and tie count, one compare per cycle.
// Start edge to done pulse is N-1 cycles; writes and starts are ignored while not idle.
module cmp_max_scan
    import cmp_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          CLK,
    input  logic          nRST,
    cmp_max_scan_if.slave bus
);
    localparam logic [IW:0]   NUM_ENTRIES = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_entry [N];
    logic [IW-1:0] r_ptr;
    logic [W-1:0]  r_max_val;
    logic [IW-1:0] r_max_idx;
    logic [IW:0]   r_tie_cnt;

    logic          w_busy;
    logic          w_done;
    logic          w_last;
    logic          w_wr_ok;
    logic [W-1:0]  w_cur;
    cmp_res_t      w_res;

    assign w_cur   = r_entry[r_ptr];
    assign w_last  = (r_ptr == LAST_IDX);
    // Out-of-range addresses only exist for non-power-of-2 N; they are dropped.
    assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < NUM_ENTRIES);

    cmp_unit #(.W(W)) u_cmp (
        .i_a   (w_cur),
        .i_b   (r_max_val),
        .o_res (w_res)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = SCAN;
            SCAN:    if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            SCAN:    w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < N; i++) r_entry[i] <= '0;
            r_ptr     <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
            r_tie_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Start takes priority; a same-edge write is dropped.
                    if (bus.start) begin
                        r_max_val <= r_entry[0];
                        r_max_idx <= '0;
                        r_tie_cnt <= (IW+1)'(1);
                        r_ptr     <= IW'(1);
                    end else if (w_wr_ok) begin
                        r_entry[bus.wr_addr] <= bus.wr_data;
                    end
                end
                SCAN: begin
                    if (w_res == GT) begin
                        r_max_val <= w_cur;
                        r_max_idx <= r_ptr;
                        r_tie_cnt <= (IW+1)'(1);
                    end else if (w_res == EQ) begin
                        r_tie_cnt <= r_tie_cnt + (IW+1)'(1);
                    end
                    if (!w_last) r_ptr <= r_ptr + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.max_val = r_max_val;
    assign bus.max_idx = r_max_idx;
    assign bus.tie_cnt = r_tie_cnt;
endmodule

// File: tb/tb_cmp_max_scan.sv
// Directed bench for cmp_max_scan (N=8, W=4) with hand-computed expected results.
module tb_cmp_max_scan;
    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;
    logic [3:0] vec [8];

    cmp_max_scan_if bus ();

    cmp_max_scan dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'(i);
            bus.wr_data = vec[i];
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Waits for done, counting busy cycles, then checks results and the single-cycle pulse.
    task automatic wait_check(input string tag, input int ecyc,
                              input int emax, input int eidx, input int etie);
        int cyc;
        int bcnt;
        cyc  = 0;
        bcnt = 0;
        while (!bus.done && cyc < 20) begin
            if (bus.busy) bcnt++;
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, ecyc);
        chk({tag, "_busycyc"}, bcnt, ecyc);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
        chk({tag, "_max"}, bus.max_val, emax);
        chk({tag, "_idx"}, bus.max_idx, eidx);
        chk({tag, "_tie"}, bus.tie_cnt, etie);
        tick();
        chk({tag, "_done_1cyc"}, bus.done, 0);
        chk({tag, "_persist"}, bus.max_val, emax);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        nrst        = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_max", bus.max_val, 0);
        chk("rst_tie", bus.tie_cnt, 0);
        nrst = 1'b1;
        tick();

        // Reset mid-scan aborts immediately.
        vec = '{4'h3, 4'h9, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7};
        load();
        do_start();
        tick();
        tick();
        chk("pre_rst_max", bus.max_val, 9);
        nrst = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_max", bus.max_val, 0);
        chk("arst_idx", bus.max_idx, 0);
        chk("arst_tie", bus.tie_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("arst_no_done", bus.done, 0);
        end
        nrst = 1'b1;
        tick();
        do_start();
        wait_check("zero_file", 7, 0, 0, 8);

        vec = '{4'h2, 4'h7, 4'h1, 4'hF, 4'h4, 4'h0, 4'hA, 4'h3};
        load();
        do_start();
        wait_check("distinct", 7, 15, 3, 1);

        vec = '{4'h5, 4'h9, 4'h9, 4'h1, 4'h9, 4'h0, 4'h2, 4'h8};
        load();
        do_start();
        wait_check("ties", 7, 9, 1, 3);

        vec = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        load();
        do_start();
        wait_check("all_f", 7, 15, 0, 8);

        vec = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE};
        load();
        do_start();
        wait_check("last_slot", 7, 14, 7, 1);

        // Back-to-back: the start right after the done-cycle tick is accepted.
        do_start();
        wait_check("b2b", 7, 14, 7, 1);

        // Writes and starts during SCAN are ignored.
        vec = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        load();
        do_start();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd6;
        bus.wr_data = 4'hF;
        bus.start   = 1'b1;
        tick();
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        wait_check("freeze", 5, 8, 7, 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd6;
        bus.wr_data = 4'hF;
        tick();
        bus.wr_en = 1'b0;
        do_start();
        wait_check("post_freeze", 7, 15, 6, 1);

        // Start and write on the same edge: start wins, write is dropped.
        vec = '{4'h3, 4'h1, 4'h1, 4'h2, 4'h1, 4'h0, 4'h2, 4'h1};
        load();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 4'hF;
        do_start();
        bus.wr_en = 1'b0;
        wait_check("collide", 7, 3, 0, 1);
        do_start();
        wait_check("collide_after", 7, 3, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cmp_max_scan.md
Name: cmp_max_scan

Overview:
- Sequencer that runs a 4-bit magnitude comparator over a small register file to find the maximum value, its first index, and its tie count.
- Host loads N entries, pulses start, and reads the results when done pulses.
- Sits beside the comparator datapath as its controller: scheduling one compare per cycle and owning the running-max state.

Parameters:
- N, 8, number of entries (2..16)
- W, 4, entry width in bits
- IW, 3, index width; must equal clog2(N)

Ports:
- CLK  input  1  system clock; all state changes on its rising edge
- nRST  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe for the entry file
- wr_addr  input  IW  entry index to write
- wr_data  input  W  value to write
- start  input  1  begin scan; sampled on CLK rise
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse when results are valid
- max_val  output  W  largest entry found
- max_idx  output  IW  lowest index holding max_val
- tie_cnt  output  IW+1  number of entries equal to max_val (1..N)

Behaviour:
- Reset (nRST low, asynchronous):
  - state=IDLE; all entries=0.
  - busy=0, done=0, max_val=0, max_idx=0, tie_cnt=0, internal ptr=0.
  - Reset asserted mid-scan aborts immediately; no done pulse is produced.
- States:
  - IDLE: busy=0, done=0.
    - wr_en=1 writes entry[wr_addr]=wr_data at the edge.
    - start=1 loads max_val=entry[0], max_idx=0, tie_cnt=1, ptr=1, then goes to SCAN.
  - SCAN: busy=1. Each cycle entry[ptr] is compared against max_val, unsigned:
    - greater: max_val=entry[ptr], max_idx=ptr, tie_cnt=1
    - equal: tie_cnt+1
    - less: no change
    - ptr increments; after processing ptr==N-1, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(N-1). For N=8, done is visible 7 cycles after the start edge, and the next start is accepted at E(N+1).
- Results persist in IDLE until the next accepted start.
- Ties: strict greater-than only, so max_idx always reports the first occurrence.
- Ignored inputs:
  - start while in SCAN or DONE
  - wr_en while in SCAN or DONE (entry file is frozen during a scan)
- Simultaneous start and wr_en in IDLE: start wins and the write is dropped.
- wr_addr >= N (non-power-of-2 N): write ignored.
- No wrap: ptr never exceeds N-1. tie_cnt maximum is N, which fits IW+1 bits.

Decomposition:
- Package cmp_pkg:
  - state enum {IDLE, SCAN, DONE}, 2-bit encoding
  - default constants N, W, IW
  - compare-result encoding {LT, EQ, GT}
- Sub-module cmp_unit: purely combinational W-bit unsigned compare, outputs lt/eq/gt one-hot.
  - One instance only; the controller muxes entry[ptr] and max_val into it.
- Entry file, ptr and FSM live in cmp_max_scan.

Test Plan:
- Reset check: assert nRST low mid-SCAN after loading {3,9,...} -> busy=0, done=0, all outputs 0 immediately; a subsequent start on an unwritten file returns max_val=0, max_idx=0, tie_cnt=8.
- Distinct max: load {2,7,1,F,4,0,A,3}, pulse start -> done exactly 7 cycles after start edge with max_val=F, max_idx=3, tie_cnt=1; busy high for 7 cycles.
- Ties: load {5,9,9,1,9,0,2,8} -> max_val=9, max_idx=1, tie_cnt=3.
- Edge values: all entries F -> max_idx=0, tie_cnt=8. Max only in last slot, {0,0,0,0,0,0,0,E} -> max_idx=7, tie_cnt=1.
- Freeze during scan: during SCAN, write entry[6]=F and re-pulse start -> both ignored; result matches the pre-scan contents; after DONE the write is accepted and the next scan sees F at index 6.
- Collision: in IDLE, drive start with wr_en to wr_addr=0, wr_data=F on the same edge -> scan uses the old entry[0]; entry[0] remains unchanged afterwards.
